axi4_lite_master_arbiter: RTL and testbench

Shares one AXI4-Lite master port between `NREQ` local requesters, each issuing single read or write commands over a simple req/done interface. The block arbitrates round-robin, runs exactly one AXI4-Lite transaction at a time on the shared bus, and returns the read data and response to the winning requester. It sits between on-chip command sources and the AXI4-Lite interconnect.

---
 rtl/axi4_lite_pkg.sv | 8 +
 rtl/axi4_lite_rr_arbiter.sv | 25 ++
 rtl/axi4_lite_master_arbiter.sv | 121 ++++++++++++
 tb/tb_axi4_lite_master_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: shared AXI4-Lite response codes and arbiter state encoding
package axi4_lite_pkg;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;
    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE} state_t;
endpackage

// File: rtl/axi4_lite_rr_arbiter.sv
// axi4_lite_rr_arbiter: combinational round-robin grant, first request at or after ptr wins
module axi4_lite_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx
);
    // scan from farthest to nearest offset so the nearest requester overwrites the rest
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            int j;
            j = int'(ptr) + i;
            j = (j >= NREQ) ? j - NREQ : j;
            if (req[j]) begin
                gnt = NREQ'(1) << j;
                idx = PW'(j);
            end
        end
    end
endmodule

// File: rtl/axi4_lite_master_arbiter.sv
// axi4_lite_master_arbiter: round-robin sharing of one AXI4-Lite master port, one transaction at a time
module axi4_lite_master_arbiter
    import axi4_lite_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        we,
    input  logic [NREQ*AW-1:0]     addr,
    input  logic [NREQ*3-1:0]      prot,
    input  logic [NREQ*DW-1:0]     wdata,
    input  logic [NREQ*DW/8-1:0]   wstrb,
    output logic [NREQ-1:0]        done,
    output logic [DW-1:0]          rdata,
    output logic [1:0]             resp,
    output logic                   busy,
    output logic [AW-1:0]          awaddr_out,
    output logic [2:0]             awprot_out,
    output logic                   awvalid_out,
    input  logic                   awready_in,
    output logic [DW-1:0]          wdata_out,
    output logic [DW/8-1:0]        wstrb_out,
    output logic                   wvalid_out,
    input  logic                   wready_in,
    input  logic [1:0]             bresp_in,
    input  logic                   bvalid_in,
    output logic                   bready_out,
    output logic [AW-1:0]          araddr_out,
    output logic [2:0]             arprot_out,
    output logic                   arvalid_out,
    input  logic                   arready_in,
    input  logic [DW-1:0]          rdata_in,
    input  logic [1:0]             rresp_in,
    input  logic                   rvalid_in,
    output logic                   rready_out
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state, state_nx;
    logic [PW-1:0]   ptr, gidx;
    logic [NREQ-1:0] gnt, win_oh;
    logic            aw_ok, w_ok;

    axi4_lite_rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gidx)
    );

    // state register, command latch, channel handshake flags and response capture
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= IDLE;
            ptr        <= '0;
            win_oh     <= '0;
            aw_ok      <= 1'b0;
            w_ok       <= 1'b0;
            awaddr_out <= '0;
            araddr_out <= '0;
            awprot_out <= '0;
            arprot_out <= '0;
            wdata_out  <= '0;
            wstrb_out  <= '0;
            rdata      <= '0;
            resp       <= OKAY;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (|req) begin
                    win_oh     <= gnt;
                    ptr        <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                    aw_ok      <= 1'b0;
                    w_ok       <= 1'b0;
                    awaddr_out <= addr[gidx*AW +: AW];
                    araddr_out <= addr[gidx*AW +: AW];
                    awprot_out <= prot[gidx*3 +: 3];
                    arprot_out <= prot[gidx*3 +: 3];
                    wdata_out  <= wdata[gidx*DW +: DW];
                    wstrb_out  <= wstrb[gidx*(DW/8) +: DW/8];
                end
                WADDR: begin
                    if (awvalid_out && awready_in) aw_ok <= 1'b1;
                    if (wvalid_out && wready_in) w_ok <= 1'b1;
                end
                WRESP: if (bvalid_in) resp <= bresp_in;
                RDATA: if (rvalid_in) begin
                    rdata <= rdata_in;
                    resp  <= rresp_in;
                end
                default: ;
            endcase
        end
    end

    // next-state: AW and W may be accepted in either order before moving on
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|req) state_nx = we[gidx] ? WADDR : RADDR;
            WADDR:   if ((aw_ok || awready_in) && (w_ok || wready_in)) state_nx = WRESP;
            WRESP:   if (bvalid_in) state_nx = DONE;
            RADDR:   if (arready_in) state_nx = RDATA;
            RDATA:   if (rvalid_in) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign awvalid_out = (state == WADDR) && !aw_ok;
    assign wvalid_out  = (state == WADDR) && !w_ok;
    assign bready_out  = (state == WRESP);
    assign arvalid_out = (state == RADDR);
    assign rready_out  = (state == RDATA);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE) ? win_oh : '0;
endmodule

// File: tb/tb_axi4_lite_master_arbiter.sv
// tb_axi4_lite_master_arbiter: directed self-checking bench for the AXI4-Lite master arbiter
module tb_axi4_lite_master_arbiter;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic [1:0]  req, we, done;
    logic [63:0] addr, wdata;
    logic [5:0]  prot;
    logic [7:0]  wstrb;
    logic [31:0] rdata, awaddr_out, wdata_out, araddr_out, rdata_in;
    logic [1:0]  resp, bresp_in, rresp_in;
    logic [2:0]  awprot_out, arprot_out;
    logic [3:0]  wstrb_out;
    logic        busy, awvalid_out, awready_in, wvalid_out, wready_in, bvalid_in, bready_out;
    logic        arvalid_out, arready_in, rvalid_in, rready_out;
    int          n_chk = 0;
    int          n_fail = 0;

    axi4_lite_master_arbiter #(.NREQ(2), .AW(32), .DW(32)) dut (
        .aclk(aclk), .aresetn(aresetn), .req(req), .we(we), .addr(addr), .prot(prot),
        .wdata(wdata), .wstrb(wstrb), .done(done), .rdata(rdata), .resp(resp), .busy(busy),
        .awaddr_out(awaddr_out), .awprot_out(awprot_out), .awvalid_out(awvalid_out),
        .awready_in(awready_in), .wdata_out(wdata_out), .wstrb_out(wstrb_out),
        .wvalid_out(wvalid_out), .wready_in(wready_in), .bresp_in(bresp_in),
        .bvalid_in(bvalid_in), .bready_out(bready_out), .araddr_out(araddr_out),
        .arprot_out(arprot_out), .arvalid_out(arvalid_out), .arready_in(arready_in),
        .rdata_in(rdata_in), .rresp_in(rresp_in), .rvalid_in(rvalid_in), .rready_out(rready_out)
    );

    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        aresetn = 0; req = 0; we = 0; addr = 0; prot = 0; wdata = 0; wstrb = 0;
        awready_in = 0; wready_in = 0; bresp_in = 0; bvalid_in = 0;
        arready_in = 0; rdata_in = 0; rresp_in = 0; rvalid_in = 0;
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_awvalid", awvalid_out, 0);
        chk("rst_arvalid", arvalid_out, 0);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_resp", resp, 0);
        chk("rst_awaddr", awaddr_out, 0);
        aresetn = 1;
        // single write by requester 0
        req = 2'b01; we = 2'b01; addr[31:0] = 32'd16; wdata[31:0] = 32'hF0B4A596;
        wstrb[3:0] = 4'b1011; prot[2:0] = 3'd4; awready_in = 1; wready_in = 1;
        step();
        chk("w1_awvalid", awvalid_out, 1);
        chk("w1_wvalid", wvalid_out, 1);
        chk("w1_awaddr", awaddr_out, 16);
        chk("w1_wdata", wdata_out, 32'hF0B4A596);
        chk("w1_wstrb", wstrb_out, 4'b1011);
        chk("w1_awprot", awprot_out, 4);
        chk("w1_busy", busy, 1);
        chk("w1_arvalid", arvalid_out, 0);
        step();
        chk("w1_bready", bready_out, 1);
        chk("w1_awvalid_drop", awvalid_out, 0);
        chk("w1_wvalid_drop", wvalid_out, 0);
        bvalid_in = 1; bresp_in = 2'b00;
        step();
        chk("w1_done", done, 2'b01);
        chk("w1_resp", resp, 0);
        req = 0; bvalid_in = 0; awready_in = 0; wready_in = 0;
        step();
        chk("w1_done_clear", done, 0);
        chk("w1_idle", busy, 0);
        // single read by requester 1 with arready delayed
        req = 2'b10; we = 2'b00; addr[63:32] = 32'd16; prot[5:3] = 3'd2;
        rdata_in = 32'hF0B4A596; rresp_in = 2'b00;
        step();
        chk("r1_arvalid_c1", arvalid_out, 1);
        chk("r1_araddr_c1", araddr_out, 16);
        chk("r1_arprot", arprot_out, 2);
        step();
        chk("r1_arvalid_c2", arvalid_out, 1);
        chk("r1_araddr_c2", araddr_out, 16);
        step();
        chk("r1_arvalid_c3", arvalid_out, 1);
        chk("r1_araddr_c3", araddr_out, 16);
        arready_in = 1;
        step();
        chk("r1_arvalid_drop", arvalid_out, 0);
        chk("r1_rready", rready_out, 1);
        arready_in = 0; rvalid_in = 1;
        step();
        chk("r1_done", done, 2'b10);
        chk("r1_rdata", rdata, 32'hF0B4A596);
        chk("r1_resp", resp, 0);
        req = 0; rvalid_in = 0;
        step();
        chk("r1_idle", busy, 0);
        // split write acceptance, requester 0, slave error on B
        req = 2'b01; we = 2'b01; addr[31:0] = 32'h20; awready_in = 1; wready_in = 0;
        step();
        chk("sw_awvalid", awvalid_out, 1);
        chk("sw_wvalid", wvalid_out, 1);
        step();
        chk("sw_awvalid_drop", awvalid_out, 0);
        chk("sw_wvalid_hold1", wvalid_out, 1);
        chk("sw_bready_lo1", bready_out, 0);
        chk("sw_wdata_hold", wdata_out, 32'hF0B4A596);
        awready_in = 0;
        step();
        chk("sw_wvalid_hold2", wvalid_out, 1);
        chk("sw_bready_lo2", bready_out, 0);
        wready_in = 1;
        step();
        chk("sw_wvalid_drop", wvalid_out, 0);
        chk("sw_bready", bready_out, 1);
        wready_in = 0; bvalid_in = 1; bresp_in = 2'b10;
        step();
        chk("sw_done", done, 2'b01);
        chk("sw_resp", resp, 2'b10);
        req = 0; bvalid_in = 0;
        step();
        chk("sw_done_once1", done, 0);
        step();
        chk("sw_done_once2", done, 0);
        chk("sw_idle", busy, 0);
        // read error from requester 1, ready/valid left high to expose any retry
        req = 2'b10; we = 2'b00; arready_in = 1; rvalid_in = 1; rresp_in = 2'b11; rdata_in = 32'h12345678;
        step();
        chk("er_arvalid", arvalid_out, 1);
        step();
        chk("er_rready", rready_out, 1);
        step();
        chk("er_done", done, 2'b10);
        chk("er_resp", resp, 2'b11);
        chk("er_rdata", rdata, 32'h12345678);
        req = 0;
        step();
        chk("er_no_retry1", arvalid_out, 0);
        chk("er_idle", busy, 0);
        step();
        chk("er_no_retry2", arvalid_out, 0);
        chk("er_no_done", done, 0);
        // contention: both requesters held from reset, reads completing immediately
        aresetn = 0; req = 2'b11; we = 2'b00; rresp_in = 2'b00;
        step();
        chk("ct_rst_busy", busy, 0);
        aresetn = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("ct_arvalid", arvalid_out, 1);
            step();
            step();
            chk("ct_done", done, (k % 2 == 0) ? 2'b01 : 2'b10);
            step();
            chk("ct_idle", busy, 0);
        end
        // reset during WRESP, then ptr must restart at 0
        req = 2'b01; we = 2'b11; awready_in = 1; wready_in = 1; bvalid_in = 0;
        arready_in = 0; rvalid_in = 0; addr[31:0] = 32'h40; addr[63:32] = 32'h44;
        step();
        chk("rw_awvalid", awvalid_out, 1);
        step();
        chk("rw_bready", bready_out, 1);
        aresetn = 0; req = 0;
        step();
        chk("rw_bready_rst", bready_out, 0);
        chk("rw_awvalid_rst", awvalid_out, 0);
        chk("rw_wvalid_rst", wvalid_out, 0);
        chk("rw_arvalid_rst", arvalid_out, 0);
        chk("rw_rready_rst", rready_out, 0);
        chk("rw_done_rst", done, 0);
        chk("rw_busy_rst", busy, 0);
        aresetn = 1; req = 2'b11;
        step();
        chk("rw_next_awvalid", awvalid_out, 1);
        chk("rw_next_awaddr", awaddr_out, 32'h40);
        step();
        bvalid_in = 1; bresp_in = 2'b00;
        step();
        chk("rw_next_done", done, 2'b01);
        req = 0; bvalid_in = 0;
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
